// File: rtl/register_file_m1.sv
// Architectural register file with per-register pending-write counters for RAW/WAW hazard detection.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle writeback data and readiness to the read ports.
module register_file_m1 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              wb_en,
    input  logic              issue_valid,
    input  logic              issue_writes,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic              issue_stall,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_ready,
    output logic              rs2_ready,
    output logic              rd_pending,
    output logic              sb_underflow
);

    localparam int unsigned NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] cnt_q  [NREG];
    logic [PEND_W-1:0] cnt_d  [NREG];
    logic              underflow_q, underflow_d;

    logic              wb_hit;
    logic              acc;
    logic              ret;
    logic [PEND_W-1:0] dest_cnt;
    logic [PEND_W-1:0] wb_cnt;

    always_comb begin
        dest_cnt    = cnt_q[issue_dest];
        wb_cnt      = cnt_q[wb_dest];
        wb_hit      = wb_en && (wb_dest != '0);
        // A same-cycle retire to the full register deliberately does not lift the stall.
        issue_stall = issue_valid && issue_writes && (issue_dest != '0) && (dest_cnt == CNT_MAX);
        acc         = issue_valid && issue_writes && (issue_dest != '0) && !issue_stall;
        ret         = wb_hit && (wb_cnt != '0);
        rd_pending  = (issue_dest != '0) && (dest_cnt != '0);
        underflow_d = underflow_q || (wb_hit && (wb_cnt == '0));
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            cnt_d[i]  = cnt_q[i];
            if (wb_hit && (wb_dest == ADDR_W'(i)) && (i != 0)) begin
                regs_d[i] = wb_data;
            end
            // acc never targets a full counter and ret never a zero one, so no wrap is possible.
            if (acc && (issue_dest == ADDR_W'(i)) && !(ret && (wb_dest == ADDR_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + PEND_W'(1);
            end else if (ret && (wb_dest == ADDR_W'(i)) && !(acc && (issue_dest == ADDR_W'(i)))) begin
                cnt_d[i] = cnt_q[i] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            underflow_q <= 1'b0;
        end else if (clk_en) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        sb_underflow = underflow_q;
        rs1_data     = '0;
        rs1_ready    = 1'b1;
        rs2_data     = '0;
        rs2_ready    = 1'b1;
        if (rs1_addr != '0) begin
            rs1_data  = regs_q[rs1_addr];
            rs1_ready = (cnt_q[rs1_addr] == '0);
`ifdef REGFILE_WB_BYPASS_EN
            if (wb_en && (wb_dest == rs1_addr)) begin
                rs1_data  = wb_data;
                rs1_ready = (cnt_q[rs1_addr] <= PEND_W'(1));
            end
`endif
        end
        if (rs2_addr != '0) begin
            rs2_data  = regs_q[rs2_addr];
            rs2_ready = (cnt_q[rs2_addr] == '0);
`ifdef REGFILE_WB_BYPASS_EN
            if (wb_en && (wb_dest == rs2_addr)) begin
                rs2_data  = wb_data;
                rs2_ready = (cnt_q[rs2_addr] <= PEND_W'(1));
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file_m1.sv
// Scoreboard bench for register_file_m1: stimulus queues expected outputs, a negedge monitor compares them.
module tb_register_file_m1;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en;
    logic [15:0] wb_data;
    logic [3:0]  wb_dest;
    logic        wb_en;
    logic        issue_valid;
    logic        issue_writes;
    logic [3:0]  issue_dest;
    logic        issue_stall;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        rs1_ready;
    logic        rs2_ready;
    logic        rd_pending;
    logic        sb_underflow;

    register_file_m1 #(.DATA_W(16), .ADDR_W(4), .PEND_W(2)) dut (
        .clk          (clk),
        .async_rst_n  (async_rst_n),
        .clk_en       (clk_en),
        .wb_data      (wb_data),
        .wb_dest      (wb_dest),
        .wb_en        (wb_en),
        .issue_valid  (issue_valid),
        .issue_writes (issue_writes),
        .issue_dest   (issue_dest),
        .issue_stall  (issue_stall),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rs1_ready    (rs1_ready),
        .rs2_ready    (rs2_ready),
        .rd_pending   (rd_pending),
        .sb_underflow (sb_underflow)
    );

    always #5 clk = ~clk;

    // mask bits: 0 rs1_data, 1 rs2_data, 2 rs1_ready, 3 rs2_ready, 4 rd_pending, 5 issue_stall, 6 sb_underflow
    typedef struct {
        string       name;
        logic [6:0]  mask;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        r1;
        logic        r2;
        logic        pend;
        logic        stall;
        logic        uf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, act, req);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.mask[0]) chk(e.name, "rs1_data",     rs1_data,            e.d1);
            if (e.mask[1]) chk(e.name, "rs2_data",     rs2_data,            e.d2);
            if (e.mask[2]) chk(e.name, "rs1_ready",    {15'd0, rs1_ready},   {15'd0, e.r1});
            if (e.mask[3]) chk(e.name, "rs2_ready",    {15'd0, rs2_ready},   {15'd0, e.r2});
            if (e.mask[4]) chk(e.name, "rd_pending",   {15'd0, rd_pending},  {15'd0, e.pend});
            if (e.mask[5]) chk(e.name, "issue_stall",  {15'd0, issue_stall}, {15'd0, e.stall});
            if (e.mask[6]) chk(e.name, "sb_underflow", {15'd0, sb_underflow},{15'd0, e.uf});
        end
    end

    task automatic expect_out(input string n, input logic [6:0] m,
                              input logic [15:0] d1, input logic [15:0] d2,
                              input logic r1, input logic r2, input logic pend,
                              input logic stall, input logic uf);
        exp_t e;
        e.name = n; e.mask = m; e.d1 = d1; e.d2 = d2;
        e.r1 = r1; e.r2 = r2; e.pend = pend; e.stall = stall; e.uf = uf;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clk_en = 1'b1; wb_en = 1'b0; wb_dest = 4'd0; wb_data = 16'h0;
        issue_valid = 1'b0; issue_writes = 1'b0; issue_dest = 4'd0;
        rs1_addr = 4'd0; rs2_addr = 4'd0;
    endtask

    task automatic wb(input logic [3:0] d, input logic [15:0] v);
        wb_en = 1'b1; wb_dest = d; wb_data = v;
    endtask

    task automatic issue(input logic [3:0] d);
        issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        async_rst_n = 1'b0;
        tick(); tick();
        async_rst_n = 1'b1;

        // reset state
        rs1_addr = 4'd5; rs2_addr = 4'd0;
        expect_out("reset", 7'h7F, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // issue to r3, then writeback
        idle(); issue(4'd3);
        expect_out("issue_r3", 7'h30, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        tick();
        idle(); rs1_addr = 4'd3; issue_dest = 4'd3;
        expect_out("r3_pending", 7'h15, 16'h0, 0, 1'b0, 0, 1'b1, 0, 0);
        tick();
        idle(); rs1_addr = 4'd3; wb(4'd3, 16'hBEEF);
        expect_out("r3_wb_cycle", 7'h05, BYP ? 16'hBEEF : 16'h0, 0, BYP, 0, 0, 0, 0);
        tick();
        idle(); rs1_addr = 4'd3;
        expect_out("r3_after_wb", 7'h45, 16'hBEEF, 0, 1'b1, 0, 0, 0, 1'b0);
        tick();

        // fill r7 to max, then stall
        for (int i = 0; i < 3; i++) begin
            idle(); issue(4'd7);
            expect_out("issue_r7", 7'h20, 0, 0, 0, 0, 0, 1'b0, 0);
            tick();
        end
        idle(); issue(4'd7); rs1_addr = 4'd7; rs2_addr = 4'd7;
        expect_out("r7_full_stall", 7'h3C, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        tick();
        idle(); issue(4'd7); wb(4'd7, 16'h1111); rs1_addr = 4'd7;
        expect_out("r7_stall_with_wb", 7'h34, 0, 0, 1'b0, 0, 1'b1, 1'b1, 0);
        tick();
        idle(); wb(4'd7, 16'h2222); rs1_addr = 4'd7;
        expect_out("r7_wb2", 7'h04, 0, 0, 1'b0, 0, 0, 0, 0);
        tick();
        idle(); wb(4'd7, 16'h3333); rs1_addr = 4'd7;
        expect_out("r7_wb3", 7'h05, BYP ? 16'h3333 : 16'h2222, 0, BYP, 0, 0, 0, 0);
        tick();
        idle(); rs1_addr = 4'd7; issue_dest = 4'd7;
        expect_out("r7_drained", 7'h15, 16'h3333, 0, 1'b1, 0, 1'b0, 0, 0);
        tick();

        // simultaneous issue and retire on r4
        idle(); issue(4'd4);
        tick();
        idle(); issue(4'd4); wb(4'd4, 16'h4444);
        expect_out("r4_acc_ret", 7'h30, 0, 0, 0, 0, 1'b1, 1'b0, 0);
        tick();
        idle(); issue_dest = 4'd4; rs2_addr = 4'd4;
        expect_out("r4_cnt_held", 7'h1A, 0, 16'h4444, 0, 1'b0, 1'b1, 0, 0);
        tick();

        // r0 writes and issues are ignored
        idle(); wb(4'd0, 16'h1234); rs1_addr = 4'd0;
        expect_out("r0_wb_cycle", 7'h05, 16'h0, 0, 1'b1, 0, 0, 0, 0);
        tick();
        idle(); issue(4'd0); rs1_addr = 4'd0;
        expect_out("r0_issue", 7'h75, 16'h0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        tick();

        // clk_en low holds state
        idle(); clk_en = 1'b0; wb(4'd5, 16'h5555); issue(4'd6);
        tick();
        idle(); rs1_addr = 4'd5; rs2_addr = 4'd6;
        expect_out("clk_en_hold", 7'h4F, 16'h0, 16'h0, 1'b1, 1'b1, 0, 0, 1'b0);
        tick();

        // underflow on r9
        idle(); wb(4'd9, 16'hABCD);
        expect_out("uf_wb_cycle", 7'h40, 0, 0, 0, 0, 0, 0, 1'b0);
        tick();
        idle(); rs1_addr = 4'd9;
        expect_out("uf_set", 7'h45, 16'hABCD, 0, 1'b1, 0, 0, 0, 1'b1);
        tick();
        idle();
        expect_out("uf_sticky", 7'h40, 0, 0, 0, 0, 0, 0, 1'b1);
        tick();

        // async reset mid-stream
        idle(); issue(4'd6);
        tick();
        idle(); rs1_addr = 4'd4; rs2_addr = 4'd6; issue_dest = 4'd6;
        expect_out("pre_reset", 7'h5F, 16'h4444, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        tick();
        async_rst_n = 1'b0;
        #1;
        expect_out("in_reset", 7'h5F, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        tick();
        async_rst_n = 1'b1;
        idle(); wb(4'd4, 16'h7777);
        tick();
        idle(); rs1_addr = 4'd4;
        expect_out("post_reset_uf", 7'h45, 16'h7777, 0, 1'b1, 0, 0, 0, 1'b1);
        tick();

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
